// File: rtl/irq_arbiter_pkg.sv
// irq_arbiter_pkg: gateway states and register word offsets for the interrupt arbiter
package irq_arbiter_pkg;
   typedef enum logic [1:0] {GW_IDLE, GW_PEND, GW_INSVC} gw_state_e;
   localparam logic [5:0] IRQ_PEND      = 6'h00;
   localparam logic [5:0] IRQ_ENABLE    = 6'h01;
   localparam logic [5:0] IRQ_TRIG      = 6'h02;
   localparam logic [5:0] IRQ_THRESH    = 6'h03;
   localparam logic [5:0] IRQ_CLAIM     = 6'h04;
   localparam logic [5:0] IRQ_PRIO_BASE = 6'h08;
endpackage

// File: rtl/irq_arbiter_gateway.sv
// irq_gateway: per-channel IDLE/PEND/INSVC tracker with edge detector and 1-deep edge hold
module irq_gateway
   import irq_arbiter_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic src_i,
   input  logic trig_i,
   input  logic claim_i,
   input  logic complete_i,
   output logic pend_o
);
   gw_state_e state_q, state_d;
   logic hold_q, hold_d, prev_q, ev;
   always_comb begin
      ev = trig_i ? (src_i & ~prev_q) : src_i;
      state_d = state_q;
      hold_d = hold_q;
      unique case (state_q)
         GW_IDLE: state_d = ev ? GW_PEND : GW_IDLE;
         GW_PEND: begin
            state_d = claim_i ? GW_INSVC : GW_PEND;
            hold_d = hold_q | (trig_i & ev);
         end
         GW_INSVC: begin
            // a held edge (or one arriving with the complete) re-pends; one new edge stays held
            state_d = complete_i ? ((ev | (trig_i & hold_q)) ? GW_PEND : GW_IDLE) : GW_INSVC;
            hold_d = complete_i ? (trig_i & hold_q & ev) : (hold_q | (trig_i & ev));
         end
         default: state_d = GW_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= GW_IDLE;
         hold_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q <= hold_d;
         prev_q <= src_i;
      end
   end
   assign pend_o = (state_q == GW_PEND);
endmodule

// File: rtl/irq_arbiter.sv
// irq_arbiter: external-interrupt controller with register port, priority arbiter and ex_trap_o
// Define IRQ_SYNC_EN to add a 2-flop synchronizer on every source.
module irq_arbiter
   import irq_arbiter_pkg::*;
#(
   parameter int IRQ_NUM = 8,
   parameter int PRIO_W  = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [IRQ_NUM-1:0] irq_src_i,
   input  logic [5:0]         reg_addr_i,
   input  logic               reg_we_i,
   input  logic               reg_re_i,
   input  logic [31:0]        reg_wdata_i,
   output logic [31:0]        reg_rdata_o,
   output logic               ex_trap_o
);
   localparam int ID_W = $clog2(IRQ_NUM + 1);
   logic [IRQ_NUM-1:0] src_s, pend, claim, complete;
   logic [IRQ_NUM-1:0] enable_q, enable_d, trig_q, trig_d;
   logic [PRIO_W-1:0]  thresh_q, thresh_d, win_prio;
   logic [PRIO_W-1:0]  prio_q [IRQ_NUM];
   logic [PRIO_W-1:0]  prio_d [IRQ_NUM];
   logic [31:0]        rdata_q, rdata_d, rsel;
   logic               trap_q, trap_d, unused_wdata;
   logic [ID_W-1:0]    win_id, cpl_id;

`ifdef IRQ_SYNC_EN
   logic [IRQ_NUM-1:0] sync1_q, sync2_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= irq_src_i;
         sync2_q <= sync1_q;
      end
   end
   assign src_s = sync2_q;
`else
   assign src_s = irq_src_i;
`endif

   genvar g;
   for (g = 0; g < IRQ_NUM; g++) begin : gw
      irq_gateway u_gw (
         .clk        (clk),
         .rst_n      (rst_n),
         .src_i      (src_s[g]),
         .trig_i     (trig_q[g]),
         .claim_i    (claim[g]),
         .complete_i (complete[g]),
         .pend_o     (pend[g])
      );
   end

   // strict compare keeps the lowest ID on ties; starting at 0 masks PRIO=0
   always_comb begin
      win_id = '0;
      win_prio = '0;
      for (int i = 0; i < IRQ_NUM; i++)
         if (pend[i] && enable_q[i] && prio_q[i] > win_prio) begin
            win_prio = prio_q[i];
            win_id = ID_W'(i + 1);
         end
   end

   always_comb begin
      cpl_id = reg_wdata_i[ID_W-1:0];
      for (int i = 0; i < IRQ_NUM; i++) begin
         claim[i] = reg_re_i && reg_addr_i == IRQ_CLAIM && win_id == ID_W'(i + 1);
         complete[i] = reg_we_i && reg_addr_i == IRQ_CLAIM && cpl_id == ID_W'(i + 1);
      end
   end

   always_comb begin
      enable_d = (reg_we_i && reg_addr_i == IRQ_ENABLE) ? reg_wdata_i[IRQ_NUM-1:0] : enable_q;
      trig_d = (reg_we_i && reg_addr_i == IRQ_TRIG) ? reg_wdata_i[IRQ_NUM-1:0] : trig_q;
      thresh_d = (reg_we_i && reg_addr_i == IRQ_THRESH) ? reg_wdata_i[PRIO_W-1:0] : thresh_q;
      rsel = reg_addr_i == IRQ_PEND   ? 32'(pend)     :
             reg_addr_i == IRQ_ENABLE ? 32'(enable_q) :
             reg_addr_i == IRQ_TRIG   ? 32'(trig_q)   :
             reg_addr_i == IRQ_THRESH ? 32'(thresh_q) :
             reg_addr_i == IRQ_CLAIM  ? 32'(win_id)   : 32'd0;
      for (int i = 0; i < IRQ_NUM; i++) begin
         prio_d[i] = (reg_we_i && reg_addr_i == IRQ_PRIO_BASE + 6'(i)) ? reg_wdata_i[PRIO_W-1:0] : prio_q[i];
         if (reg_addr_i == IRQ_PRIO_BASE + 6'(i)) rsel = 32'(prio_q[i]);
      end
      rdata_d = reg_re_i ? rsel : rdata_q;
      trap_d = win_prio > thresh_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enable_q <= '0;
         trig_q <= '0;
         thresh_q <= '0;
         rdata_q <= '0;
         trap_q <= 1'b0;
         for (int i = 0; i < IRQ_NUM; i++) prio_q[i] <= '0;
      end else begin
         enable_q <= enable_d;
         trig_q <= trig_d;
         thresh_q <= thresh_d;
         rdata_q <= rdata_d;
         trap_q <= trap_d;
         prio_q <= prio_d;
      end
   end

   assign unused_wdata = ^reg_wdata_i;
   assign reg_rdata_o = rdata_q;
   assign ex_trap_o = trap_q;
endmodule
